// File: rtl/softmax_pkg.sv
// softmax_pkg
// Shared definitions for the top-2 classifier that sits behind the softmax
// stage: float format width, lane count, class index width, the canonical
// zero encoding and the scan state machine encoding.
package softmax_pkg;

  localparam int FLOAT_WIDTH = 8;
  localparam int NUM_CLASSES = 7;
  localparam int CLASS_IDX_W = 3;
  localparam logic [FLOAT_WIDTH-1:0] FLOAT_ZERO = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WAIT
  } ScanState;

endpackage

// File: rtl/float_cmp8.sv
// float_cmp8
// Combinational strict greater-than for the 8-bit float format
// sign[7] | exponent[6:3] | mantissa[2:0]. There are no NaN/Inf semantics;
// every encoding is an ordinary ordered value.
//
// Ports:
//   a, b : operands (raw float bits)
//   gt   : 1 when a is strictly greater than b
module float_cmp8
  import softmax_pkg::*;
(
  input  logic [FLOAT_WIDTH-1:0] a,
  input  logic [FLOAT_WIDTH-1:0] b,
  output logic                   gt
);

  logic aZero;
  logic bZero;
  logic aNeg;
  logic bNeg;

  // A zero magnitude is treated as positive regardless of its sign bit, so
  // +0 and -0 fall into the same bucket and compare equal. Sign-magnitude
  // ordering: positive beats negative, positives order by magnitude bits,
  // negatives order in reverse.
  always_comb begin
    aZero = (a[FLOAT_WIDTH-2:0] == '0);
    bZero = (b[FLOAT_WIDTH-2:0] == '0);
    aNeg  = a[FLOAT_WIDTH-1] & ~aZero;
    bNeg  = b[FLOAT_WIDTH-1] & ~bZero;
    gt    = 1'b0;
    if (aNeg != bNeg) begin
      gt = bNeg;
    end else if (!aNeg) begin
      gt = (a[FLOAT_WIDTH-2:0] > b[FLOAT_WIDTH-2:0]);
    end else begin
      gt = (a[FLOAT_WIDTH-2:0] < b[FLOAT_WIDTH-2:0]);
    end
  end

endmodule

// File: rtl/softmax_argmax.sv
// softmax_argmax
// Sequential top-2 classifier. On a fresh rising edge of probs_valid the
// packed probability vector is copied into a shadow register, then one lane
// per cycle is folded into a running top1/top2 pair. After the last lane the
// result registers are written and done pulses for one cycle.
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   probs        : packed lanes, lane i at probs[DATA_WIDTH*i +: DATA_WIDTH]
//   probs_valid  : level valid from the softmax stage
//   busy         : high while scanning lanes
//   done         : one-cycle pulse when a new result is written
//   top1_idx     : winning class index
//   top1_prob    : winning probability (raw float bits)
//   top2_idx     : runner-up class index
//   confident    : top1_prob >= CONF_THRESH
module softmax_argmax
  import softmax_pkg::*;
#(
  parameter int                DATA_WIDTH  = 8,
  parameter int                NUM_CLASSES = 7,
  parameter logic [DATA_WIDTH-1:0] CONF_THRESH = 8'h30
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH*NUM_CLASSES-1:0] probs,
  input  logic                             probs_valid,
  output logic                             busy,
  output logic                             done,
  output logic [CLASS_IDX_W-1:0]           top1_idx,
  output logic [DATA_WIDTH-1:0]            top1_prob,
  output logic [CLASS_IDX_W-1:0]           top2_idx,
  output logic                             confident
);

  ScanState state;
  ScanState nextState;

  logic                              prevValid;
  logic                              risingValid;
  logic [DATA_WIDTH*NUM_CLASSES-1:0] shadow;
  logic [CLASS_IDX_W-1:0]            idx;
  logic                              lastLane;

  logic                   run1Valid;
  logic [DATA_WIDTH-1:0]  run1Prob;
  logic [CLASS_IDX_W-1:0] run1Idx;
  logic                   run2Valid;
  logic [DATA_WIDTH-1:0]  run2Prob;
  logic [CLASS_IDX_W-1:0] run2Idx;

  logic [DATA_WIDTH-1:0]  laneProb;
  logic                   laneGtTop1;
  logic                   laneGtTop2;
  logic                   threshGtTop1;

  logic                   new1Valid;
  logic [DATA_WIDTH-1:0]  new1Prob;
  logic [CLASS_IDX_W-1:0] new1Idx;
  logic                   new2Valid;
  logic [DATA_WIDTH-1:0]  new2Prob;
  logic [CLASS_IDX_W-1:0] new2Idx;

  logic captureEn;
  logic laneEn;
  logic writeEn;

  assign risingValid = probs_valid & ~prevValid;
  assign lastLane    = (idx == CLASS_IDX_W'(NUM_CLASSES - 1));
  assign laneProb    = shadow[DATA_WIDTH*int'(idx) +: DATA_WIDTH];
  assign busy        = (state == SCAN);

  float_cmp8 cmpTop1 (
    .a  (laneProb),
    .b  (run1Prob),
    .gt (laneGtTop1)
  );

  float_cmp8 cmpTop2 (
    .a  (laneProb),
    .b  (run2Prob),
    .gt (laneGtTop2)
  );

  // The threshold is checked against the top1 value that is about to be
  // written, so it sees the final lane's contribution in the same cycle.
  float_cmp8 cmpThresh (
    .a  (CONF_THRESH),
    .b  (new1Prob),
    .gt (threshGtTop1)
  );

  // Fold the current lane into the running pair. Strict greater-than means an
  // equal later lane never displaces an earlier one, so ties keep the lower
  // index. The second lane naturally lands in top2 (or pushes top1 down)
  // because top2 is still empty at that point.
  always_comb begin
    new1Valid = run1Valid;
    new1Prob  = run1Prob;
    new1Idx   = run1Idx;
    new2Valid = run2Valid;
    new2Prob  = run2Prob;
    new2Idx   = run2Idx;
    if (!run1Valid) begin
      new1Valid = 1'b1;
      new1Prob  = laneProb;
      new1Idx   = idx;
    end else if (laneGtTop1) begin
      new2Valid = 1'b1;
      new2Prob  = run1Prob;
      new2Idx   = run1Idx;
      new1Prob  = laneProb;
      new1Idx   = idx;
    end else if (!run2Valid || laneGtTop2) begin
      new2Valid = 1'b1;
      new2Prob  = laneProb;
      new2Idx   = idx;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and control strobes. A scan starts only on a fresh rising
  // edge; dropping valid mid-scan abandons the vector without touching the
  // result registers.
  always_comb begin
    nextState = state;
    captureEn = 1'b0;
    laneEn    = 1'b0;
    writeEn   = 1'b0;
    unique case (state)
      IDLE: begin
        if (risingValid) begin
          captureEn = 1'b1;
          nextState = SCAN;
        end
      end
      SCAN: begin
        if (!probs_valid) begin
          nextState = IDLE;
        end else begin
          laneEn = 1'b1;
          if (lastLane) begin
            writeEn   = 1'b1;
            nextState = WAIT;
          end
        end
      end
      WAIT: begin
        if (!probs_valid) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Datapath: valid history, shadow capture, lane walk and result registers.
  // The index stops at the last lane so the lane mux never reads past the
  // shadow vector while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prevValid <= 1'b0;
      shadow    <= '0;
      idx       <= '0;
      run1Valid <= 1'b0;
      run1Prob  <= FLOAT_ZERO;
      run1Idx   <= '0;
      run2Valid <= 1'b0;
      run2Prob  <= FLOAT_ZERO;
      run2Idx   <= '0;
      done      <= 1'b0;
      top1_idx  <= '0;
      top1_prob <= FLOAT_ZERO;
      top2_idx  <= '0;
      confident <= 1'b0;
    end else begin
      prevValid <= probs_valid;
      done      <= writeEn;
      if (captureEn) begin
        shadow    <= probs;
        idx       <= '0;
        run1Valid <= 1'b0;
        run1Prob  <= FLOAT_ZERO;
        run1Idx   <= '0;
        run2Valid <= 1'b0;
        run2Prob  <= FLOAT_ZERO;
        run2Idx   <= '0;
      end
      if (laneEn) begin
        run1Valid <= new1Valid;
        run1Prob  <= new1Prob;
        run1Idx   <= new1Idx;
        run2Valid <= new2Valid;
        run2Prob  <= new2Prob;
        run2Idx   <= new2Idx;
        if (!lastLane) begin
          idx <= idx + CLASS_IDX_W'(1);
        end
      end
      if (writeEn) begin
        top1_idx  <= new1Idx;
        top1_prob <= new1Prob;
        top2_idx  <= new2Idx;
        confident <= ~threshGtTop1;
      end
    end
  end

endmodule

// File: tb/tb_softmax_argmax.sv
// tb_softmax_argmax
// Self-checking bench for softmax_argmax. Expected results come from a model
// that converts each lane to a real number and ranks lanes directly.
module tb_softmax_argmax;

  localparam int NC = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [8*NC-1:0] probs;
  logic          probs_valid;
  logic          busy;
  logic          done;
  logic [2:0]    top1_idx;
  logic [7:0]    top1_prob;
  logic [2:0]    top2_idx;
  logic          confident;

  int checks   = 0;
  int failures = 0;

  softmax_argmax dut (
    .clk         (clk),
    .reset       (reset),
    .probs       (probs),
    .probs_valid (probs_valid),
    .busy        (busy),
    .done        (done),
    .top1_idx    (top1_idx),
    .top1_prob   (top1_prob),
    .top2_idx    (top2_idx),
    .confident   (confident)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Numeric value of a lane: 2^(e-7)*(1+m/8), subnormal below e=1, zero of
  // either sign is 0.0.
  function automatic real toReal(input logic [7:0] f);
    int  e;
    int  m;
    real p;
    real mag;
    e = int'(f[6:3]);
    m = int'(f[2:0]);
    if (f[6:0] == 7'd0) return 0.0;
    if (e == 0) begin
      mag = real'(m) / 512.0;
    end else begin
      p = 1.0;
      for (int k = 0; k < e; k++) p = p * 2.0;
      mag = (1.0 + real'(m) / 8.0) * p / 128.0;
    end
    return f[7] ? -mag : mag;
  endfunction

  // Ranking: best lane with lowest index on ties, then best of the rest.
  task automatic modelResult(input logic [8*NC-1:0] vec, output int t1,
                             output int t2, output bit conf);
    real v[NC];
    for (int i = 0; i < NC; i++) v[i] = toReal(vec[8*i +: 8]);
    t1 = 0;
    for (int i = 1; i < NC; i++) if (v[i] > v[t1]) t1 = i;
    t2 = -1;
    for (int i = 0; i < NC; i++)
      if (i != t1 && (t2 < 0 || v[i] > v[t2])) t2 = i;
    conf = (v[t1] >= 0.5);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8*NC-1:0] randomVec();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[8*NC-1:0];
  endfunction

  task automatic checkResult(input string tag, input logic [8*NC-1:0] vec);
    int t1;
    int t2;
    bit conf;
    logic [7:0] lane;
    modelResult(vec, t1, t2, conf);
    lane = vec[8*t1 +: 8];
    checkOutput({tag, ".top1Idx"}, 32'(top1_idx), 32'(t1));
    checkOutput({tag, ".top1Prob"}, 32'(top1_prob), 32'(lane));
    checkOutput({tag, ".top2Idx"}, 32'(top2_idx), 32'(t2));
    checkOutput({tag, ".confident"}, 32'(confident), 32'(conf));
  endtask

  // Raise valid with vec, scramble probs during the scan, expect done on the
  // eighth edge (capture edge plus seven lanes), then release valid.
  task automatic applyStimulus(input string tag, input logic [8*NC-1:0] vec);
    int cycles;
    bit seen;
    probs       = vec;
    probs_valid = 1'b1;
    cycles      = 0;
    seen        = 1'b0;
    while (!seen && cycles < 20) begin
      nextCycle();
      cycles++;
      if (cycles == 1) checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
      probs = randomVec();
      if (done) seen = 1'b1;
    end
    checkOutput({tag, ".latency"}, 32'(cycles), 32'd8);
    checkResult(tag, vec);
    nextCycle();
    checkOutput({tag, ".doneDrop"}, 32'(done), 32'd0);
    probs_valid = 1'b0;
    nextCycle();
  endtask

  initial begin
    logic [8*NC-1:0] vecA;
    logic [8*NC-1:0] vecB;
    logic [63:0]     pick;
    int              doneCount;

    reset       = 1'b1;
    probs_valid = 1'b0;
    probs       = '0;
    repeat (3) nextCycle();
    checkOutput("reset.outputs",
                32'({busy, done, top1_idx, top1_prob, top2_idx, confident}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nextCycle();

    vecA = {8'h20, 8'h20, 8'h20, 8'h20, 8'h38, 8'h28, 8'h20};
    applyStimulus("plan1", vecA);
    applyStimulus("ties", {NC{8'h28}});
    applyStimulus("thresh", {8'h30, {6{8'h18}}});
    applyStimulus("zeros", {8'hA0, 8'hA0, 8'h00, 8'hA0, 8'h80, 8'hA0, 8'hA0});

    // Abort: previous result must survive, then a fresh edge rescans.
    applyStimulus("preAbort", vecA);
    vecB = {8'h10, 8'h3A, 8'h08, 8'h00, 8'h3A, 8'h22, 8'h31};
    probs       = vecB;
    probs_valid = 1'b1;
    repeat (3) nextCycle();
    probs_valid = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      if (done) doneCount++;
    end
    checkOutput("abort.noDone", 32'(doneCount), 32'd0);
    checkOutput("abort.busy", 32'(busy), 32'd0);
    checkResult("abort.hold", vecA);
    applyStimulus("rescan", vecB);

    // Long valid level yields exactly one pulse.
    vecB = {8'h29, 8'h41, 8'h41, 8'h12, 8'h7F, 8'hFF, 8'h2F};
    probs       = vecB;
    probs_valid = 1'b1;
    doneCount   = 0;
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      probs = randomVec();
      if (done) doneCount++;
    end
    checkOutput("hold.oneDone", 32'(doneCount), 32'd1);
    checkResult("hold", vecB);
    probs_valid = 1'b0;
    nextCycle();

    // Reset in the middle of a scan.
    applyStimulus("preReset", vecA);
    probs       = {8'h3F, {6{8'h01}}};
    probs_valid = 1'b1;
    repeat (3) nextCycle();
    reset       = 1'b1;
    probs_valid = 1'b0;
    #1;
    checkOutput("midReset.outputs",
                32'({busy, done, top1_idx, top1_prob, top2_idx, confident}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      if (done) doneCount++;
    end
    checkOutput("midReset.noDone", 32'(doneCount), 32'd0);

    // Randomized vectors: arbitrary bytes, positive-only, and tie-heavy sets.
    for (int n = 0; n < 36; n++) begin
      vecB = randomVec();
      if (n % 3 == 1) begin
        for (int i = 0; i < NC; i++) vecB[8*i+7] = 1'b0;
      end else if (n % 3 == 2) begin
        pick = {$urandom(), $urandom()};
        for (int i = 0; i < NC; i++) begin
          case (pick[2*i +: 2])
            2'd0:    vecB[8*i +: 8] = 8'h28;
            2'd1:    vecB[8*i +: 8] = 8'h30;
            2'd2:    vecB[8*i +: 8] = 8'h80;
            default: vecB[8*i +: 8] = 8'h00;
          endcase
        end
      end
      applyStimulus($sformatf("rand%0d", n), vecB);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/softmax_argmax.md
# softmax_argmax

Sequential top-2 classifier sitting directly downstream of the 7-class softmax stage. It captures the packed 8-bit float probability vector when the softmax raises its valid level, scans the seven lanes one per cycle, and reports the winning class, its probability, the runner-up class, and a confidence flag. It issues a single-cycle completion pulse per softmax result.

## Interface
- DATA_WIDTH, 8: float width. Format is sign[7] | exponent[6:3] | mantissa[2:0], bias 7.
- NUM_CLASSES, 7: number of lanes. Lane i is `probs[DATA_WIDTH*i +: DATA_WIDTH]`.
- CONF_THRESH, 8'h30: confidence threshold, 0.5 in this format.

- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- probs  in  DATA_WIDTH*NUM_CLASSES  packed softmax outputs.
- probs_valid  in  1  level from softmax valid_o; held high while the result is stable.
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse when a new result is written.
- top1_idx  out  3  winning class index.
- top1_prob  out  DATA_WIDTH  winning probability (raw float bits).
- top2_idx  out  3  runner-up class index.
- confident  out  1  top1_prob >= CONF_THRESH.

## Operation
- Reset values: busy=0, done=0, top1_idx=0, top1_prob=0, top2_idx=0, confident=0, state=IDLE, internal index=0, prev_valid=0.
- Result registers change only at the last SCAN cycle. They hold through IDLE/WAIT and through aborts.
- States:
  - IDLE: on a sampled rising edge of probs_valid (now 1, previous sample 0), latch the whole probs vector into a shadow register. Clear running top1/top2 to "empty" and set idx=0. Go to SCAN. A probs_valid already high when leaving reset or WAIT does not start a scan; a fresh rising edge is required.
  - SCAN: each cycle, compare shadow lane idx against the running top1/top2, then idx++. When idx==NUM_CLASSES-1 is processed, write the outputs, pulse done, and go to WAIT. If probs_valid is sampled 0 during SCAN, abort to IDLE with no done pulse and no output update.
  - WAIT: stay until probs_valid is sampled 0, then go to IDLE.
- Float compare gt(a,b):
  - ±0 compare equal.
  - Signs differ: the positive operand is greater.
  - Both positive: unsigned compare of bits[6:0].
  - Both negative: reversed compare.
  - Exponent 4'hF is treated as an ordinary value; there are no NaN/Inf semantics.
- Update rule per lane x at index i:
  - First lane: top1=x.
  - Second lane: ordered into top1/top2.
  - Otherwise, if gt(x,top1): top2←top1 and top1←x. Else if top2 is empty or gt(x,top2): top2←x.
  - Strict gt means ties keep the lower index.
- confident computed at write: !gt(CONF_THRESH, top1_prob).
- Shadow register isolates the scan from changes in probs during SCAN.

## Timing
- Edge E0 samples the rising edge and captures probs. Edges E1..E7 process lanes 0..6.
- Outputs and done=1 are visible after E7; done drops after E8.
- Latency: 7 cycles from the capture edge to the result. busy is high after E0 through E7.
- Minimum restart: probs_valid low for ≥1 sampled cycle, then high again.
- reset mid-SCAN: immediate return to reset values with no done.

## Structure
- Package softmax_pkg holds:
  - FLOAT_WIDTH=8, NUM_CLASSES=7, CLASS_IDX_W=3, FLOAT_ZERO=8'h00.
  - State enum {IDLE, SCAN, WAIT}.
- Sub-module float_cmp8: combinational gt(a,b) per the rules above. Instantiate it twice, once against top1 and once against top2; the CONF_THRESH compare reuses the top1 instance at write time or uses a third instance.

## Test plan
- Lanes {0x20,0x28,0x38,0x20,0x20,0x20,0x20} (lane 2 = 1.0), raise probs_valid → done after 7 cycles; top1_idx=2, top1_prob=0x38, top2_idx=1, confident=1.
- All lanes 0x28 → top1_idx=0, top2_idx=1 (tie rule), confident=0.
- Lane 6=0x30 and others 0x18 → top1_idx=6, top1_prob=0x30, confident=1 (equal to threshold).
- Drop probs_valid at the 3rd SCAN cycle → no done; outputs keep the previous result; a new rising edge rescans correctly.
- Hold probs_valid high for 20 cycles → exactly one done pulse. Change probs during SCAN → result reflects the captured vector.
- Lanes with 0x80 (−0) and 0x00 (+0), rest 0xA0 (negative) → top1_idx is the lowest-index zero lane. Asserting reset mid-SCAN clears all outputs to 0 with no done.
